// File: rtl/imply_pkg.sv
// Shared definitions for the sequential LUT implication engine.
// Holds the 2-bit pin encoding, the FSM state type and small pin helpers
// used by both the chunk evaluator and the top level.
package imply_pkg;

    localparam logic [1:0] PIN_ZERO    = 2'b00;
    localparam logic [1:0] PIN_ONE     = 2'b01;
    localparam logic [1:0] PIN_UNKNOWN = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Only 00/01 count as an assignment; 2'b10 is folded into UNKNOWN.
    function automatic logic pin_assigned(input logic [1:0] p);
        return (p == PIN_ZERO) || (p == PIN_ONE);
    endfunction

    // Turn "value seen in some consistent row" flags into a pin encoding.
    function automatic logic [1:0] pin_resolve(input logic seen0, input logic seen1);
        logic [1:0] r;
        r = PIN_UNKNOWN;
        if (seen0 && !seen1) begin
            r = PIN_ZERO;
        end else if (seen1 && !seen0) begin
            r = PIN_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/imply_chunk_eval.sv
// Combinational evaluation of one chunk of truth-table rows.
// Ports:
//   pins_i      captured pin assignment (pin i at [2i+1:2i], output pin on top)
//   base_i      address of the first row in this chunk
//   tt_chunk_i  truth-table bits for rows base_i .. base_i+CHUNK_BITS-1
//   any_o       some row in the chunk is consistent with pins_i
//   seen0_o/seen1_o   input pin i is 0/1 in some consistent row
//   oseen0_o/oseen1_o the output bit is 0/1 in some consistent row
module imply_chunk_eval
    import imply_pkg::*;
#(
    parameter int unsigned LUT_SIZE   = 8,
    parameter int unsigned CHUNK_BITS = 16
) (
    input  logic [2*LUT_SIZE+1:0] pins_i,
    input  logic [LUT_SIZE-1:0]   base_i,
    input  logic [CHUNK_BITS-1:0] tt_chunk_i,
    output logic                  any_o,
    output logic [LUT_SIZE-1:0]   seen0_o,
    output logic [LUT_SIZE-1:0]   seen1_o,
    output logic                  oseen0_o,
    output logic                  oseen1_o
);

    logic [1:0]          out_pin;
    logic [LUT_SIZE-1:0] addr;
    logic                row_ok;

    assign out_pin = pins_i[2*LUT_SIZE +: 2];

    always_comb begin
        any_o    = 1'b0;
        seen0_o  = '0;
        seen1_o  = '0;
        oseen0_o = 1'b0;
        oseen1_o = 1'b0;
        addr     = '0;
        row_ok   = 1'b0;
        for (int j = 0; j < int'(CHUNK_BITS); j++) begin
            addr   = base_i + LUT_SIZE'(j);
            row_ok = 1'b1;
            for (int i = 0; i < int'(LUT_SIZE); i++) begin
                if (pin_assigned(pins_i[2*i +: 2]) && (pins_i[2*i] != addr[i])) begin
                    row_ok = 1'b0;
                end
            end
            if (pin_assigned(out_pin) && (out_pin[0] != tt_chunk_i[j])) begin
                row_ok = 1'b0;
            end
            if (row_ok) begin
                any_o = 1'b1;
                for (int i = 0; i < int'(LUT_SIZE); i++) begin
                    if (addr[i]) seen1_o[i] = 1'b1;
                    else         seen0_o[i] = 1'b1;
                end
                if (tt_chunk_i[j]) oseen1_o = 1'b1;
                else               oseen0_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imply_seq.sv
// Sequential LUT implication engine with an ap_ctrl_chain-style handshake.
// Captures pins/tt on accept, scans CHUNK_BITS truth-table rows per cycle,
// then presents forced pin values until the consumer asserts ap_continue.
// Ports:
//   ap_clk, ap_rst (sync, active high), ap_ce (clock enable)
//   ap_start/ap_ready/ap_idle/ap_done/ap_continue  block handshake
//   pins, tt        job inputs, sampled only in the accept cycle
//   implied_pins    forced values, same layout as pins
//   conflict        no truth-table row is consistent with pins
//   changed         some UNKNOWN pin became ZERO/ONE
module imply_seq
    import imply_pkg::*;
#(
    parameter int unsigned LUT_SIZE   = 8,
    parameter int unsigned CHUNK_BITS = 16,
    localparam int unsigned TRUTH_TABLE_BITS = 1 << LUT_SIZE,
    localparam int unsigned PIN_W            = 2 * LUT_SIZE + 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_ce,
    input  logic                        ap_start,
    input  logic                        ap_continue,
    output logic                        ap_idle,
    output logic                        ap_ready,
    output logic                        ap_done,
    input  logic [PIN_W-1:0]            pins,
    input  logic [TRUTH_TABLE_BITS-1:0] tt,
    output logic [PIN_W-1:0]            implied_pins,
    output logic                        conflict,
    output logic                        changed
);

    localparam int unsigned N_CHUNKS = TRUTH_TABLE_BITS / CHUNK_BITS;
    localparam int unsigned IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    state_e                      state_q, state_d;
    logic [PIN_W-1:0]            pins_q, pins_d;
    logic [TRUTH_TABLE_BITS-1:0] tt_q, tt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        any_q, any_d;
    logic [LUT_SIZE-1:0]         seen0_q, seen0_d, seen1_q, seen1_d;
    logic                        oseen0_q, oseen0_d, oseen1_q, oseen1_d;
    logic [PIN_W-1:0]            implied_q, implied_d;
    logic                        conflict_q, conflict_d;
    logic                        changed_q, changed_d;

    // Current chunk evaluation
    logic [LUT_SIZE-1:0]   chunk_base;
    logic [CHUNK_BITS-1:0] tt_chunk;
    logic                  c_any, c_oseen0, c_oseen1;
    logic [LUT_SIZE-1:0]   c_seen0, c_seen1;

    // Accumulators including the current chunk; used to form the final result
    logic                acc_any, acc_oseen0, acc_oseen1;
    logic [LUT_SIZE-1:0] acc_seen0, acc_seen1;
    logic [PIN_W-1:0]    res_pins;
    logic                res_changed;

    assign chunk_base = LUT_SIZE'(idx_q) << $clog2(CHUNK_BITS);
    assign tt_chunk   = CHUNK_BITS'(tt_q >> chunk_base);

    imply_chunk_eval #(
        .LUT_SIZE   (LUT_SIZE),
        .CHUNK_BITS (CHUNK_BITS)
    ) u_chunk_eval (
        .pins_i     (pins_q),
        .base_i     (chunk_base),
        .tt_chunk_i (tt_chunk),
        .any_o      (c_any),
        .seen0_o    (c_seen0),
        .seen1_o    (c_seen1),
        .oseen0_o   (c_oseen0),
        .oseen1_o   (c_oseen1)
    );

    assign acc_any    = any_q | c_any;
    assign acc_seen0  = seen0_q | c_seen0;
    assign acc_seen1  = seen1_q | c_seen1;
    assign acc_oseen0 = oseen0_q | c_oseen0;
    assign acc_oseen1 = oseen1_q | c_oseen1;

    // Assigned pins resolve to their own value automatically: every
    // consistent row agrees with them, so only one seen flag can be set.
    always_comb begin
        res_pins    = '1;
        res_changed = 1'b0;
        if (acc_any) begin
            for (int i = 0; i < int'(LUT_SIZE); i++) begin
                res_pins[2*i +: 2] = pin_resolve(acc_seen0[i], acc_seen1[i]);
            end
            res_pins[2*LUT_SIZE +: 2] = pin_resolve(acc_oseen0, acc_oseen1);
        end
        for (int i = 0; i <= int'(LUT_SIZE); i++) begin
            if (!pin_assigned(pins_q[2*i +: 2]) && pin_assigned(res_pins[2*i +: 2])) begin
                res_changed = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pins_d     = pins_q;
        tt_d       = tt_q;
        idx_d      = idx_q;
        any_d      = any_q;
        seen0_d    = seen0_q;
        seen1_d    = seen1_q;
        oseen0_d   = oseen0_q;
        oseen1_d   = oseen1_q;
        implied_d  = implied_q;
        conflict_d = conflict_q;
        changed_d  = changed_q;
        ap_idle    = 1'b0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    ap_ready = ap_ce && !ap_rst;
                    state_d  = StScan;
                    pins_d   = pins;
                    tt_d     = tt;
                    idx_d    = '0;
                    any_d    = 1'b0;
                    seen0_d  = '0;
                    seen1_d  = '0;
                    oseen0_d = 1'b0;
                    oseen1_d = 1'b0;
                end
            end
            StScan: begin
                any_d    = acc_any;
                seen0_d  = acc_seen0;
                seen1_d  = acc_seen1;
                oseen0_d = acc_oseen0;
                oseen1_d = acc_oseen1;
                if (idx_q == LAST_IDX) begin
                    idx_d      = '0;
                    state_d    = StDone;
                    implied_d  = res_pins;
                    conflict_d = !acc_any;
                    changed_d  = res_changed;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                ap_done = 1'b1;
                if (ap_continue) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset wins over ap_ce; with ap_ce low every register holds.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= StIdle;
            pins_q     <= '1;
            tt_q       <= '0;
            idx_q      <= '0;
            any_q      <= 1'b0;
            seen0_q    <= '0;
            seen1_q    <= '0;
            oseen0_q   <= 1'b0;
            oseen1_q   <= 1'b0;
            implied_q  <= '1;
            conflict_q <= 1'b0;
            changed_q  <= 1'b0;
        end else if (ap_ce) begin
            state_q    <= state_d;
            pins_q     <= pins_d;
            tt_q       <= tt_d;
            idx_q      <= idx_d;
            any_q      <= any_d;
            seen0_q    <= seen0_d;
            seen1_q    <= seen1_d;
            oseen0_q   <= oseen0_d;
            oseen1_q   <= oseen1_d;
            implied_q  <= implied_d;
            conflict_q <= conflict_d;
            changed_q  <= changed_d;
        end
    end

    assign implied_pins = implied_q;
    assign conflict     = conflict_q;
    assign changed      = changed_q;

endmodule

// File: tb/tb_imply_seq.sv
// Directed bench for imply_seq: a small (2,1) instance for hand-traceable
// AND cases and a default (8,16) instance for XOR, stall and reset cases.
module tb_imply_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small instance: LUT_SIZE=2, CHUNK_BITS=1 (N=4)
    logic       s_rst, s_ce, s_start, s_cont;
    logic       s_idle, s_ready, s_done, s_conf, s_chg;
    logic [5:0] s_pins, s_impl;
    logic [3:0] s_tt;

    // Default instance: LUT_SIZE=8, CHUNK_BITS=16 (N=16)
    logic         d_rst, d_ce, d_start, d_cont;
    logic         d_idle, d_ready, d_done, d_conf, d_chg;
    logic [17:0]  d_pins, d_impl;
    logic [255:0] d_tt;

    imply_seq #(.LUT_SIZE(2), .CHUNK_BITS(1)) dut_s (
        .ap_clk(clk), .ap_rst(s_rst), .ap_ce(s_ce), .ap_start(s_start),
        .ap_continue(s_cont), .ap_idle(s_idle), .ap_ready(s_ready), .ap_done(s_done),
        .pins(s_pins), .tt(s_tt), .implied_pins(s_impl), .conflict(s_conf),
        .changed(s_chg)
    );

    imply_seq dut_d (
        .ap_clk(clk), .ap_rst(d_rst), .ap_ce(d_ce), .ap_start(d_start),
        .ap_continue(d_cont), .ap_idle(d_idle), .ap_ready(d_ready), .ap_done(d_done),
        .pins(d_pins), .tt(d_tt), .implied_pins(d_impl), .conflict(d_conf),
        .changed(d_chg)
    );

    localparam logic [3:0]   TT_AND = 4'b1000;
    localparam logic [255:0] TT_XOR = {64{4'h6}};  // bit a = a[0] ^ a[1]
    // Default layout: out [17:16], in7..in0 at [15:0]
    localparam logic [17:0]  D_ALLU   = 18'h3FFFF;
    localparam logic [17:0]  D_IN0_1  = 18'b00_11_11_11_11_11_11_11_01;
    localparam logic [17:0]  D_IN01_1 = 18'b00_11_11_11_11_11_11_01_01;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic s_job(input string name, input logic [5:0] p, input logic [3:0] t,
                         input logic [5:0] ep, input logic ec, input logic ech);
        int c;
        @(negedge clk);
        s_pins = p; s_tt = t; s_start = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready: got %b want 1", name, s_ready);
        end
        @(negedge clk);
        s_start = 1'b0; s_pins = '0; s_tt = '0;  // later changes must not matter
        c = 1;
        while (s_done !== 1'b1 && c < 100) begin
            @(negedge clk); c++;
        end
        checks++;
        if (c != 5) begin errors++; $display("FAIL %s latency: got %0d want 5", name, c); end
        checks++;
        if (s_impl !== ep) begin
            errors++; $display("FAIL %s implied: got %b want %b", name, s_impl, ep);
        end
        checks++;
        if (s_conf !== ec || s_chg !== ech) begin
            errors++;
            $display("FAIL %s conf/chg: got %b/%b want %b/%b", name, s_conf, s_chg, ec, ech);
        end
        s_cont = 1'b1;
        @(negedge clk);
        s_cont = 1'b0;
        #1;
        checks++;
        if (s_idle !== 1'b1 || s_done !== 1'b0) begin
            errors++; $display("FAIL %s return idle: got %b/%b want 1/0", name, s_idle, s_done);
        end
    endtask

    // gap_at > 0 drops ap_ce for three cycles starting at cycle T+gap_at;
    // hold keeps ap_continue low for that many cycles in DONE.
    task automatic d_job(input string name, input logic [17:0] p, input logic [255:0] t,
                         input logic [17:0] ep, input logic ec, input logic ech,
                         input int exp_lat, input int gap_at, input int hold);
        int c;
        bit held_ok;
        @(negedge clk);
        d_pins = p; d_tt = t; d_start = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready: got %b want 1", name, d_ready);
        end
        @(negedge clk);
        d_start = 1'b0; d_pins = '0; d_tt = ~t;
        c = 1;
        while (d_done !== 1'b1 && c < 200) begin
            @(negedge clk); c++;
            if (c == gap_at) d_ce = 1'b0;
            if (c == gap_at + 3) d_ce = 1'b1;
        end
        d_ce = 1'b1;
        checks++;
        if (c != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, c, exp_lat);
        end
        checks++;
        if (d_impl !== ep) begin
            errors++; $display("FAIL %s implied: got %h want %h", name, d_impl, ep);
        end
        checks++;
        if (d_conf !== ec || d_chg !== ech) begin
            errors++;
            $display("FAIL %s conf/chg: got %b/%b want %b/%b", name, d_conf, d_chg, ec, ech);
        end
        if (hold > 0) begin
            held_ok = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (d_done !== 1'b1 || d_impl !== ep || d_chg !== ech) held_ok = 1'b0;
            end
            checks++;
            if (!held_ok) begin
                errors++; $display("FAIL %s hold: got done=%b impl=%h want 1/%h",
                                   name, d_done, d_impl, ep);
            end
        end
        d_cont = 1'b1;
        @(negedge clk);
        d_cont = 1'b0;
        #1;
        checks++;
        if (d_idle !== 1'b1 || d_done !== 1'b0) begin
            errors++; $display("FAIL %s return idle: got %b/%b want 1/0", name, d_idle, d_done);
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1; s_ce = 1'b1; s_start = 1'b0; s_cont = 1'b0; s_pins = '0; s_tt = '0;
        d_rst = 1'b1; d_ce = 1'b1; d_start = 1'b0; d_cont = 1'b0; d_pins = '0; d_tt = '0;
        repeat (2) @(negedge clk);
        s_rst = 1'b0; d_rst = 1'b0;
        #1;
        checks++;
        if ({s_idle, s_ready, s_done, s_conf, s_chg} !== 5'b10000 || s_impl !== 6'h3F) begin
            errors++; $display("FAIL reset_small: got %b impl %b want 10000 impl 111111",
                               {s_idle, s_ready, s_done, s_conf, s_chg}, s_impl);
        end
        checks++;
        if ({d_idle, d_ready, d_done, d_conf, d_chg} !== 5'b10000 || d_impl !== D_ALLU) begin
            errors++; $display("FAIL reset_default: got %b impl %h want 10000 impl %h",
                               {d_idle, d_ready, d_done, d_conf, d_chg}, d_impl, D_ALLU);
        end
    endtask

    task automatic test_and_small();
        // pins = {out, in1, in0}
        s_job("and_out1", 6'b01_11_11, TT_AND, 6'b01_01_01, 1'b0, 1'b1);
        s_job("and_out0_in0_1", 6'b00_11_01, TT_AND, 6'b00_00_01, 1'b0, 1'b1);
        s_job("and_conflict", 6'b01_11_00, TT_AND, 6'b11_11_11, 1'b1, 1'b0);
        s_job("and_enc10_unknown", 6'b01_10_11, TT_AND, 6'b01_01_01, 1'b0, 1'b1);
    endtask

    task automatic test_xor_default();
        d_job("xor_all_unknown", D_ALLU, TT_XOR, D_ALLU, 1'b0, 1'b0, 17, 0, 0);
        d_job("xor_in0_out0", D_IN0_1, TT_XOR, D_IN01_1, 1'b0, 1'b1, 17, 0, 0);
    endtask

    task automatic test_ce_stall();
        d_job("ce_stall", D_IN0_1, TT_XOR, D_IN01_1, 1'b0, 1'b1, 20, 5, 0);
    endtask

    task automatic test_continue_hold();
        d_job("continue_hold", D_IN0_1, TT_XOR, D_IN01_1, 1'b0, 1'b1, 17, 0, 5);
    endtask

    task automatic test_start_held();
        int rdy;
        int c;
        @(negedge clk);
        d_pins = D_ALLU; d_tt = TT_XOR; d_start = 1'b1;
        #1;
        rdy = (d_ready === 1'b1) ? 1 : 0;
        c = 0;
        while (d_done !== 1'b1 && c < 100) begin
            @(negedge clk); c++;
            if (d_ready === 1'b1) rdy++;
        end
        checks++;
        if (rdy != 1) begin errors++; $display("FAIL start_held_job1: got %0d readies want 1", rdy); end
        d_cont = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b0) begin
            errors++; $display("FAIL start_held_done_ready: got %b want 0", d_ready);
        end
        @(negedge clk);
        d_cont = 1'b0;
        d_pins = D_IN0_1;
        #1;
        checks++;
        if (d_idle !== 1'b1 || d_ready !== 1'b1) begin
            errors++; $display("FAIL start_held_next_accept: got %b/%b want 1/1", d_idle, d_ready);
        end
        rdy = 1;
        c = 0;
        while (d_done !== 1'b1 && c < 100) begin
            @(negedge clk); c++;
            if (d_ready === 1'b1) rdy++;
        end
        checks++;
        if (rdy != 1 || d_impl !== D_IN01_1) begin
            errors++; $display("FAIL start_held_job2: got %0d readies impl %h want 1 impl %h",
                               rdy, d_impl, D_IN01_1);
        end
        d_start = 1'b0;
        d_cont = 1'b1;
        @(negedge clk);
        d_cont = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit saw_done;
        @(negedge clk);
        d_pins = D_IN0_1; d_tt = TT_XOR; d_start = 1'b1;  // cycle T
        @(negedge clk);
        d_start = 1'b0;                                    // T+1
        repeat (5) @(negedge clk);                         // T+6
        d_rst = 1'b1;
        @(negedge clk);                                    // T+7
        d_rst = 1'b0;
        #1;
        checks++;
        if ({d_idle, d_done, d_conf, d_chg} !== 4'b1000 || d_impl !== D_ALLU) begin
            errors++; $display("FAIL mid_reset: got %b impl %h want 1000 impl %h",
                               {d_idle, d_done, d_conf, d_chg}, d_impl, D_ALLU);
        end
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (d_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL mid_reset_no_done: got done want none"); end
        d_job("after_reset", D_IN0_1, TT_XOR, D_IN01_1, 1'b0, 1'b1, 17, 0, 0);
    endtask

    initial begin
        test_reset();
        test_and_small();
        test_xor_default();
        test_ce_stall();
        test_continue_hold();
        test_start_held();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
